// File: rtl/if_id_queue_if.sv
// rtl/if_id_queue_if.sv - fetch/decode handshake bundle for the IF/ID instruction queue
//
// Purpose: groups the fetch-side push port, the pipeline stall/flush controls and
//          the decode-side head port of if_id_queue.
// Parameter: DEPTH - queue depth; sets the width of count_out ($clog2(DEPTH)+1).
// Signals:
//   instr_in, pc_in, valid_in    fetch -> queue   pushed {pc, instr} and its valid
//   ready_out                    queue -> fetch   push accepted this cycle
//   cache_stall, hazard_stall    pipeline -> queue freeze / decode hold
//   flush                        pipeline -> queue discard all entries
//   instr_out, pc_out, valid_out queue -> decode  head entry
//   count_out                    queue -> decode  occupied entries
// Modports: master = fetch/pipeline side, slave = the queue.
interface if_id_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   instr_in;
  logic [31:0]   pc_in;
  logic          valid_in;
  logic          ready_out;
  logic          cache_stall;
  logic          hazard_stall;
  logic          flush;
  logic [31:0]   instr_out;
  logic [31:0]   pc_out;
  logic          valid_out;
  logic [CW-1:0] count_out;

  modport master (
    output instr_in, pc_in, valid_in, cache_stall, hazard_stall, flush,
    input  ready_out, instr_out, pc_out, valid_out, count_out
  );

  modport slave (
    input  instr_in, pc_in, valid_in, cache_stall, hazard_stall, flush,
    output ready_out, instr_out, pc_out, valid_out, count_out
  );
endinterface

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - instruction queue between fetch and decode
//
// Purpose: circular buffer of {pc, instr} entries replacing the single IF/ID
//          register. Fetch pushes, decode pops the head. cache_stall freezes all
//          state, hazard_stall blocks only the pop, flush empties the queue.
// Parameter: DEPTH - entries, power of 2, >= 2.
// Optional feature macro: IFQ_BYPASS_EN - when defined, an instruction arriving at
//          an empty queue is presented to decode in the same cycle.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset
//   q    if_id_queue_if.slave - push port, stall/flush controls, head outputs
module if_id_queue #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  if_id_queue_if.slave  q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [63:0]   r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic w_empty;
  logic w_ready;
  logic w_bypass;
  logic w_valid;
  logic w_push;
  logic w_pop;
  logic w_write;
  logic w_deq;

  assign w_empty = (r_count == '0);
  assign w_ready = (r_count != CW'(DEPTH)) && !q.cache_stall;

`ifdef IFQ_BYPASS_EN
  assign w_bypass = w_empty && q.valid_in && !q.flush && !q.cache_stall;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_valid = !w_empty || w_bypass;
  assign w_push  = q.valid_in && w_ready && !q.flush;
  assign w_pop   = w_valid && !q.hazard_stall && !q.cache_stall && !q.flush;

  // A bypassed instruction consumed by decode in the same cycle never lands in
  // storage; the pop then refers to that instruction, not to a stored entry.
  assign w_write = w_push && !(w_bypass && w_pop);
  assign w_deq   = w_pop && !w_bypass;

  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_deq)   r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_write) - CW'(w_deq);
    end
  end

  // Storage needs no reset: contents are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (!rst && w_write) r_mem[r_wr_ptr] <= {q.pc_in, q.instr_in};
  end

  always_comb begin
    q.instr_out = NOP;
    q.pc_out    = 32'h0;
    if (!w_empty) begin
      q.pc_out    = r_mem[r_rd_ptr][63:32];
      q.instr_out = r_mem[r_rd_ptr][31:0];
    end else if (w_bypass) begin
      q.pc_out    = q.pc_in;
      q.instr_out = q.instr_in;
    end
  end

  assign q.valid_out = w_valid;
  assign q.ready_out = w_ready;
  assign q.count_out = r_count;
endmodule
